// File: rtl/uart_tx_pkg.sv
// Shared frame constants and state encodings for the UART transmitter and its companion receiver.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned CNT_W     = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic int unsigned calc_cycle(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO in front of the UART transmitter; used only when UART_TX_FIFO_EN is defined.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign rdata = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, registered tx_pin.
// Define UART_TX_FIFO_EN to put a 2**FIFO_DEPTH_LOG2 byte FIFO in front of the engine.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 27_000_000,
    parameter int unsigned BOUD_RATE       = 115200,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_pin
);

    localparam int unsigned      CYCLE     = calc_cycle(CLK_FREQ, BOUD_RATE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    if (CYCLE < 2 || CYCLE > 65535 || FIFO_DEPTH_LOG2 < 1) begin : g_bad_cfg
        $error("uart_tx: CYCLE must lie in 2..65535 and FIFO_DEPTH_LOG2 must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_pin_q, tx_pin_d;
    logic             tx_done_q, tx_done_d;

    logic             in_idle;
    logic             avail;
    logic [7:0]       src_byte;
    logic             bit_end;

    assign in_idle = (state_q == S_IDLE);

`ifdef UART_TX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;

    assign ready    = !fifo_full;
    assign avail    = !fifo_empty;
    assign src_byte = fifo_rdata;

    uart_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (send),
        .wdata (data),
        .pop   (in_idle && !fifo_empty),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    // Single-byte holding: a send while a frame is in flight is silently dropped.
    assign ready    = in_idle;
    assign avail    = send;
    assign src_byte = data;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_pin_d  = tx_pin_q;
        tx_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_pin_d = 1'b1;
                cnt_d    = '0;
                if (avail) begin
                    shift_d  = src_byte;
                    state_d  = S_START;
                    tx_pin_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = S_DATA;
                    tx_pin_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d  = S_STOP;
                        tx_pin_d = 1'b1;
                    end else begin
                        tx_pin_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        state_d   = S_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                tx_pin_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_pin_q  <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_pin_q  <= tx_pin_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign busy    = !in_idle;
    assign tx_pin  = tx_pin_q;
    assign tx_done = tx_done_q;

endmodule
